// File: rtl/bell_judge.sv
// bell_judge: round referee for the two-player card game.
//
// Keeps the top face-up card of each player, raises bell_ok whenever any colour's
// fruit total equals TARGET_SUM, edge-detects both bell keys and judges each press
// as a hit (score +1, table cleared) or a miss (score -1, saturating at 0). A short
// lock window follows every judged press. Reaching WIN_SCORE ends the game until reset.
//
// Ports:
//   clk, rst       clock; synchronous active-low reset
//   card_valid     one-cycle pulse, a card is played this cycle
//   card_player    0 = P1, 1 = P2
//   card_color     colour 1..3 (0 = none, never counted)
//   card_number    fruit count 1..5
//   bell1, bell2   raw bell key levels
//   bell_ok        some colour total equals TARGET_SUM (combinational)
//   score1/score2  player scores
//   hit / miss     one-cycle pulses for a correct / wrong judged press
//   presser        player of the last judged press, held
//   finish         game over level
//   winner         valid while finish; 0 = P1, 1 = P2
//   state          PLAY = 00, LOCK = 01, OVER = 10
module bell_judge #(
  parameter int unsigned TARGET_SUM  = 5,
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned LOCK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       card_valid,
  input  logic       card_player,
  input  logic [1:0] card_color,
  input  logic [2:0] card_number,
  input  logic       bell1,
  input  logic       bell2,
  output logic       bell_ok,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       hit,
  output logic       miss,
  output logic       presser,
  output logic       finish,
  output logic       winner,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StPlay = 2'b00,
    StLock = 2'b01,
    StOver = 2'b10
  } state_e;

  localparam logic [3:0] TargetSum = 4'(TARGET_SUM);
  localparam logic [3:0] WinScore  = 4'(WIN_SCORE);
  localparam logic [7:0] LockLoad  = 8'(LOCK_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic [1:0] top1_color_q, top1_color_d;
  logic [2:0] top1_num_q, top1_num_d;
  logic [1:0] top2_color_q, top2_color_d;
  logic [2:0] top2_num_q, top2_num_d;
  logic       bell1_q, bell2_q;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;
  logic       presser_q, presser_d;
  logic       winner_q, winner_d;

  // ---------------------------------------------------------------------------
  // Colour totals and bell condition
  // ---------------------------------------------------------------------------
  logic [3:0] color_sum [3];
  logic [2:0] sum_match;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      color_sum[c] = ((top1_color_q == 2'(c + 1)) ? {1'b0, top1_num_q} : 4'd0)
                   + ((top2_color_q == 2'(c + 1)) ? {1'b0, top2_num_q} : 4'd0);
      sum_match[c] = (color_sum[c] == TargetSum);
    end
  end

  assign bell_ok = |sum_match;

  // ---------------------------------------------------------------------------
  // Bell edges and press decode
  // ---------------------------------------------------------------------------
  logic       b1e, b2e;
  logic       press_vld;
  logic       press_who;
  logic [3:0] cur_score;
  logic [3:0] new_score;

  assign b1e       = bell1 & ~bell1_q;
  assign b2e       = bell2 & ~bell2_q;
  assign press_vld = (state_q == StPlay) && (b1e || b2e);
  // P1 wins a same-cycle tie, so P2 is the presser only when P1 has no edge.
  assign press_who = ~b1e;
  assign cur_score = press_who ? score2_q : score1_q;

  always_comb begin
    new_score = cur_score;
    if (bell_ok) begin
      new_score = cur_score + 4'd1;
    end else if (cur_score != 4'd0) begin
      new_score = cur_score - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    top1_color_d = top1_color_q;
    top1_num_d   = top1_num_q;
    top2_color_d = top2_color_q;
    top2_num_d   = top2_num_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    presser_d    = presser_q;
    winner_d     = winner_q;

    // Card write; a hit below overrides it with the table clear.
    if (card_valid && (state_q != StOver)) begin
      if (card_player) begin
        top2_color_d = card_color;
        top2_num_d   = card_number;
      end else begin
        top1_color_d = card_color;
        top1_num_d   = card_number;
      end
    end

    case (state_q)
      StPlay: begin
        if (press_vld) begin
          presser_d = press_who;
          hit_d     = bell_ok;
          miss_d    = ~bell_ok;
          if (press_who) begin
            score2_d = new_score;
          end else begin
            score1_d = new_score;
          end
          if (bell_ok) begin
            top1_color_d = 2'd0;
            top1_num_d   = 3'd0;
            top2_color_d = 2'd0;
            top2_num_d   = 3'd0;
          end
          if (new_score == WinScore) begin
            state_d  = StOver;
            winner_d = press_who;
          end else begin
            state_d    = StLock;
            lock_cnt_d = LockLoad;
          end
        end
      end
      StLock: begin
        if (lock_cnt_q == 8'd0) begin
          state_d = StPlay;
        end else begin
          lock_cnt_d = lock_cnt_q - 8'd1;
        end
      end
      StOver: begin
        // Frozen until reset.
      end
      default: begin
        state_d = StPlay;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StPlay;
      lock_cnt_q   <= 8'd0;
      top1_color_q <= 2'd0;
      top1_num_q   <= 3'd0;
      top2_color_q <= 2'd0;
      top2_num_q   <= 3'd0;
      bell1_q      <= 1'b0;
      bell2_q      <= 1'b0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      presser_q    <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      top1_color_q <= top1_color_d;
      top1_num_q   <= top1_num_d;
      top2_color_q <= top2_color_d;
      top2_num_q   <= top2_num_d;
      bell1_q      <= bell1;
      bell2_q      <= bell2;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      presser_q    <= presser_d;
      winner_q     <= winner_d;
    end
  end

  assign score1  = score1_q;
  assign score2  = score2_q;
  assign hit     = hit_q;
  assign miss    = miss_q;
  assign presser = presser_q;
  assign winner  = winner_q;
  assign finish  = (state_q == StOver);
  assign state   = state_q;

endmodule

// File: tb/tb_bell_judge.sv
// Bench for bell_judge: directed vector table, hand-written multi-cycle sequences
// and randomized stimulus, all checked against a game-level reference model.
module tb_bell_judge;

  localparam int L   = 8;
  localparam int WIN = 5;
  localparam int TGT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       card_valid = 1'b0;
  logic       card_player = 1'b0;
  logic [1:0] card_color = 2'd0;
  logic [2:0] card_number = 3'd0;
  logic       bell1 = 1'b0;
  logic       bell2 = 1'b0;
  logic       bell_ok;
  logic [3:0] score1, score2;
  logic       hit, miss, presser, finish, winner;
  logic [1:0] state;

  bell_judge #(
    .TARGET_SUM (TGT),
    .WIN_SCORE  (WIN),
    .LOCK_CYCLES(L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .card_valid (card_valid),
    .card_player(card_player),
    .card_color (card_color),
    .card_number(card_number),
    .bell1      (bell1),
    .bell2      (bell2),
    .bell_ok    (bell_ok),
    .score1     (score1),
    .score2     (score2),
    .hit        (hit),
    .miss       (miss),
    .presser    (presser),
    .finish     (finish),
    .winner     (winner),
    .state      (state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: game rules in terms of cards, scores and a time window.
  // ---------------------------------------------------------------------------
  int m_col[2]   = '{0, 0};
  int m_num[2]   = '{0, 0};
  int m_score[2] = '{0, 0};
  bit m_prev[2]  = '{0, 0};
  bit m_over = 0, m_winner = 0, m_hit = 0, m_miss = 0, m_presser = 0;
  int cyc = 0;
  int m_lock_end = 0;  // presses accepted only on edges after this index

  function automatic bit m_bell_ok();
    for (int c = 1; c <= 3; c++) begin
      int s;
      s = 0;
      for (int p = 0; p < 2; p++) if (m_col[p] == c) s += m_num[p];
      if (s == TGT) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    bit ok, e0, e1, was_over;
    int p;
    cyc++;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_col[i] = 0; m_num[i] = 0; m_score[i] = 0; m_prev[i] = 0;
      end
      m_over = 0; m_winner = 0; m_hit = 0; m_miss = 0; m_presser = 0;
      m_lock_end = cyc;
      return;
    end
    ok = m_bell_ok();
    e0 = bell1 && !m_prev[0];
    e1 = bell2 && !m_prev[1];
    m_prev[0] = bell1;
    m_prev[1] = bell2;
    m_hit = 0;
    m_miss = 0;
    was_over = m_over;
    if (!was_over && cyc > m_lock_end && (e0 || e1)) begin
      p = e0 ? 0 : 1;
      m_presser = (p == 1);
      if (ok) begin
        m_hit = 1;
        m_score[p]++;
      end else begin
        m_miss = 1;
        if (m_score[p] > 0) m_score[p]--;
      end
      if (m_score[p] == WIN) begin
        m_over = 1;
        m_winner = (p == 1);
      end else begin
        m_lock_end = cyc + L;
      end
    end
    if (!was_over && card_valid && !m_hit) begin
      m_col[int'(card_player)] = int'(card_color);
      m_num[int'(card_player)] = int'(card_number);
    end
    if (m_hit) begin
      for (int i = 0; i < 2; i++) begin
        m_col[i] = 0; m_num[i] = 0;
      end
    end
  endtask

  task automatic model_check();
    chk("bell_ok", bell_ok, m_bell_ok());
    chk("hit", hit, m_hit);
    chk("miss", miss, m_miss);
    chk("score1", score1, m_score[0]);
    chk("score2", score2, m_score[1]);
    chk("presser", presser, m_presser);
    chk("finish", finish, m_over);
    if (m_over) chk("winner", winner, m_winner);
    chk("state", state, m_over ? 2 : ((cyc < m_lock_end) ? 1 : 0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit cv; bit cp; int cc; int cn; bit b1; bit b2; int n;
    bit e_ok; bit e_hit; bit e_miss; int e_s1; int e_s2; int e_st; bit e_pr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit cv, input bit cp, input int cc, input int cn, input bit b1,
                     input bit b2, input int n, input bit e_ok, input bit e_hit,
                     input bit e_miss, input int e_s1, input int e_s2, input int e_st,
                     input bit e_pr);
    vec_t v;
    v = '{cv, cp, cc, cn, b1, b2, n, e_ok, e_hit, e_miss, e_s1, e_s2, e_st, e_pr};
    vecs.push_back(v);
  endtask

  task automatic set_in(input bit cv, input bit cp, input int cc, input int cn,
                        input bit b1, input bit b2);
    card_valid  = cv;
    card_player = cp;
    card_color  = 2'(cc);
    card_number = 3'(cn);
    bell1       = b1;
    bell2       = b2;
  endtask

  // Lay a sum-5 pair on colour 1 and press with player p, then wait n cycles.
  task automatic do_hit(input bit p, input int n);
    set_in(1, 0, 1, 1, 0, 0); tick();
    set_in(1, 1, 1, 4, 0, 0); tick();
    set_in(0, 0, 0, 0, !p, p); tick();
    chk("do_hit pulse", hit, 1);
    set_in(0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " bell_ok"}, bell_ok, 0);
    chk({tag, " score1"}, score1, 0);
    chk({tag, " score2"}, score2, 0);
    chk({tag, " hit"}, hit, 0);
    chk({tag, " miss"}, miss, 0);
    chk({tag, " presser"}, presser, 0);
    chk({tag, " finish"}, finish, 0);
    chk({tag, " winner"}, winner, 0);
    chk({tag, " state"}, state, 0);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b1;

    //  cv cp cc cn b1 b2 n   ok hit miss s1 s2 st pr
    add(1, 0, 1, 2, 0, 0, 1,  0, 0, 0,   0, 0, 0, 0);  // P1 c1 n2
    add(1, 1, 1, 3, 0, 0, 1,  1, 0, 0,   0, 0, 0, 0);  // P2 c1 n3 -> sum 5
    add(0, 0, 0, 0, 0, 1, 1,  0, 1, 0,   0, 1, 1, 1);  // P2 hit
    add(0, 0, 0, 0, 0, 1, 1,  0, 0, 0,   0, 1, 1, 1);  // held key, pulse over
    add(0, 0, 0, 0, 0, 0, 6,  0, 0, 0,   0, 1, 1, 1);  // last LOCK cycle
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0,   0, 1, 0, 1);  // back to PLAY
    add(1, 0, 2, 4, 0, 0, 1,  0, 0, 0,   0, 1, 0, 1);
    add(1, 1, 3, 1, 0, 0, 1,  0, 0, 0,   0, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1,  0, 0, 1,   0, 1, 1, 0);  // P1 miss, saturates at 0
    add(0, 0, 0, 0, 0, 0, 8,  0, 0, 0,   0, 1, 0, 0);
    add(1, 1, 2, 1, 0, 0, 1,  1, 0, 0,   0, 1, 0, 0);  // P1 card kept -> c2 sum 5
    add(0, 0, 0, 0, 1, 1, 1,  0, 1, 0,   1, 1, 1, 0);  // simultaneous, P1 wins
    add(0, 0, 0, 0, 1, 1, 20, 0, 0, 0,   1, 1, 0, 0);  // held keys, no new edges
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0,   1, 1, 0, 0);
    add(1, 0, 3, 2, 0, 0, 1,  0, 0, 0,   1, 1, 0, 0);
    add(1, 1, 3, 3, 0, 0, 1,  1, 0, 0,   1, 1, 0, 0);
    add(1, 1, 1, 5, 1, 0, 1,  0, 1, 0,   2, 1, 1, 0);  // hit + card collision
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0,   2, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1,  0, 0, 0,   2, 1, 1, 0);  // P2 edge in LOCK ignored
    add(0, 0, 0, 0, 0, 0, 7,  0, 0, 0,   2, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].cv, vecs[i].cp, vecs[i].cc, vecs[i].cn, vecs[i].b1, vecs[i].b2);
      repeat (vecs[i].n) tick();
      chk($sformatf("vec%0d bell_ok", i), bell_ok, vecs[i].e_ok);
      chk($sformatf("vec%0d hit", i), hit, vecs[i].e_hit);
      chk($sformatf("vec%0d miss", i), miss, vecs[i].e_miss);
      chk($sformatf("vec%0d score1", i), score1, vecs[i].e_s1);
      chk($sformatf("vec%0d score2", i), score2, vecs[i].e_s2);
      chk($sformatf("vec%0d state", i), state, vecs[i].e_st);
      chk($sformatf("vec%0d presser", i), presser, vecs[i].e_pr);
    end
    set_in(0, 0, 0, 0, 0, 0);

    // Win by P2
    repeat (3) do_hit(1, L);
    chk("win pre score2", score2, 4);
    do_hit(1, 2);
    chk("win score2", score2, 5);
    chk("win finish", finish, 1);
    chk("win winner", winner, 1);
    chk("win state", state, 2);
    set_in(1, 0, 1, 5, 0, 0); tick();
    set_in(0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    chk("over score1", score1, 2);
    chk("over score2", score2, 5);
    chk("over state", state, 2);
    chk("over bell_ok", bell_ok, 0);
    chk("over finish", finish, 1);

    // Reset out of OVER, then reset in the middle of LOCK with score1 = 3
    rst = 1'b0; tick(); rst = 1'b1;
    chk_all_zero("rst over");
    do_hit(0, L);
    do_hit(0, L);
    do_hit(0, 2);
    chk("lock score1", score1, 3);
    chk("lock state", state, 1);
    rst = 1'b0; tick(); rst = 1'b1;
    chk_all_zero("rst lock");

    // Randomized play against the model
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 299) != 0) && !(m_over && $urandom_range(0, 9) == 0);
      card_valid  = ($urandom_range(0, 2) == 0);
      card_player = 1'($urandom_range(0, 1));
      card_color  = 2'($urandom_range(0, 3));
      card_number = 3'($urandom_range(1, 5));
      if ($urandom_range(0, 3) == 0) bell1 = ~bell1;
      if ($urandom_range(0, 3) == 0) bell2 = ~bell2;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bell_judge.md
# bell_judge

Round referee for the two-player card game. Holds the top face-up card of each player as delivered by the card-value stage, and asserts `bell_ok` when any colour's fruit total equals the target. It also edge-detects both players' bell keys and awards or deducts points. It drives `finish` back to the turn counter when a player reaches the winning score.

## Interface
- `TARGET_SUM`, default 5: colour total that makes a bell press correct.
- `WIN_SCORE`, default 5: score that ends the game (1..15).
- `LOCK_CYCLES`, default 8: bell-ignore window after each judged press (1..255).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `card_valid` in 1: one-cycle pulse; a card is played this cycle.
- `card_player` in 1: 0 = P1 played, 1 = P2 played.
- `card_color` in 2: colour 1..3 (0 = none, not counted).
- `card_number` in 3: fruit count 1..5.
- `bell1` in 1: P1 bell key level (raw keypad decode).
- `bell2` in 1: P2 bell key level.
- `bell_ok` out 1: some colour total == `TARGET_SUM` (combinational from top-card registers).
- `score1` out 4: P1 score.
- `score2` out 4: P2 score.
- `hit` out 1: one-cycle pulse, correct press judged.
- `miss` out 1: one-cycle pulse, wrong press judged.
- `presser` out 1: player of the last judged press (0 = P1, 1 = P2); held until the next press.
- `finish` out 1: level, game over.
- `winner` out 1: valid while `finish`; 0 = P1, 1 = P2.
- `state` out 2: PLAY = 00, LOCK = 01, OVER = 10.

## Operation
- Reset values: `state` = PLAY; top cards = colour 0, number 0; all outputs = 0; bell delay registers = 0; lock counter = 0.
- Top cards: in PLAY or LOCK, `card_valid` overwrites the top card of `card_player` with {`card_color`, `card_number`}. In OVER, `card_valid` is ignored.
- Colour totals:
  - For c = 1..3, sum(c) = (top1.color==c ? top1.number : 0) + (top2.color==c ? top2.number : 0).
  - Each sum is 4 bits wide; the maximum is 10, so no overflow is possible.
  - `bell_ok` = OR over c of (sum(c) == `TARGET_SUM`).
- Bell edge detection:
  - `b1e` = `bell1` & ~`bell1_q`; `b2e` likewise for `bell2`.
  - The `_q` registers update every cycle in all states, so a held key produces exactly one edge.
- PLAY, on `b1e` or `b2e`:
  - When both edges occur in the same cycle, P1 has priority and P2's edge is discarded.
  - `presser` = pressing player.
  - If `bell_ok` (the value in the edge cycle) is 1: `hit` pulses, the presser's score is incremented, and both top cards are cleared to 0.
  - If `bell_ok` is 0: `miss` pulses, the presser's score is decremented, saturating at 0. Top cards are kept.
  - If the new score == `WIN_SCORE`, go to OVER with `winner` = presser. Otherwise go to LOCK with the counter loaded to `LOCK_CYCLES`-1.
- LOCK:
  - Bell edges are ignored (not queued).
  - The counter decrements each cycle; when it is 0, return to PLAY.
  - Cards are still accepted.
- OVER: `finish` = 1 and all scores are frozen. Only `rst` exits this state.
- A card and a bell edge in the same cycle: the press is judged against the pre-card `bell_ok`. If the press is a hit, the clear wins over the card write and the card is discarded.
- Reset mid-game: the next edge returns every register to its reset value, regardless of state.

## Timing
- `card_valid` at edge N: the top card and `bell_ok` reflect the new card after edge N, i.e. in cycle N+1.
- Bell key rising at cycle N (sampled at edge N):
  - `hit`/`miss`, the score, `presser` and the card clear are all visible in cycle N+1.
  - `state` = LOCK or OVER in cycle N+1.
- LOCK occupies exactly `LOCK_CYCLES` cycles; the first edge accepted again is sampled `LOCK_CYCLES`+1 cycles after the press.
- `finish` asserts in cycle N+1 of the winning press and stays high.
- `hit` and `miss` are never high together. Each is high for exactly one cycle.

## Test plan
- Hit: P1 plays colour 1 number 2, P2 plays colour 1 number 3, then P2 presses -> `bell_ok`=1 before the press; `hit` for 1 cycle; `score2`=1; top cards 0; `bell_ok`=0; `state`=LOCK for 8 cycles, then PLAY.
- Miss with saturation: P1 colour 2 number 4, P2 colour 3 number 1, P1 presses with `score1`=0 -> `miss`; `score1` stays 0; `bell_ok` stays 0; top cards retained.
- Simultaneous and held keys: both bells rise in the same cycle with `bell_ok`=1 -> `score1`+1 and `score2` unchanged. Holding both keys for 20 cycles produces no further judgments. A P2 edge during LOCK is ignored.
- Win: `score2`=4, a correct P2 press -> `score2`=5; `finish`=1; `winner`=1; `state`=OVER. A later card or bell changes nothing.
- Card/bell collision: with `bell_ok`=1, in the same cycle P1 presses and P2 plays colour 1 number 5 -> `hit`, cards cleared, and the new card is discarded (`bell_ok`=0 next cycle).
- Reset mid-LOCK with `score1`=3: drive `rst`=0 for 1 cycle -> all outputs 0 and `state`=PLAY on the next cycle.
